// File: rtl/mpmc10_pkg.sv
// ============================================================================
// Module : mpmc10_pkg
// Brief  : Shared sequencer state type and MIG command encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mpmc10_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } mpmc10_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mpmc10_strip_addr_gen.sv
// ============================================================================
// Module : mpmc10_strip_addr_gen
// Brief  : Strip address/index generator with last-strip flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mpmc10_strip_addr_gen #(
    parameter int ADDR_W     = 29,
    parameter int STRIP_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [5:0]        last_idx_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [5:0]        last_idx_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(STRIP_STEP);

    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        cnt_q;
    logic [5:0]        last_idx_q;

    // Address addition wraps modulo 2^ADDR_W by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
        end else if (load_i) begin
            addr_q     <= base_i;
            cnt_q      <= '0;
            last_idx_q <= last_idx_i;
        end else if (advance_i) begin
            addr_q <= addr_q + C_STEP;
            cnt_q  <= cnt_q + 6'd1;
        end
    end

    assign addr_o     = addr_q;
    assign last_idx_o = last_idx_q;
    assign last_o     = (cnt_q == last_idx_q);

endmodule

`default_nettype wire

// File: rtl/mpmc10_strip_seq.sv
// ============================================================================
// Module : mpmc10_strip_seq
// Brief  : Multi-strip MIG read/write command sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mpmc10_strip_seq
    import mpmc10_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int STRIP_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [5:0]        num_strips,
    input  logic [127:0]      wdata,
    input  logic [15:0]       wmask,
    output logic              wnext,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    input  logic [127:0]      app_rd_data,
    output logic              app_en,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [127:0]      app_wdf_data,
    output logic [15:0]       app_wdf_mask,
    output logic [127:0]      rdata,
    output logic              rdata_vld,
    output logic [5:0]        rdata_idx,
    output logic              busy,
    output logic              done
);

    mpmc10_seq_state_t state_q, state_d;

    logic              wnext_q, wnext_d;
    logic [5:0]        rd_cnt_q, rd_cnt_d;
    logic [127:0]      rdata_q, rdata_d;
    logic [5:0]        rdata_idx_q, rdata_idx_d;
    logic              rdata_vld_q, rdata_vld_d;
    logic              w_load, w_advance, w_last, w_rd_beat;
    logic [ADDR_W-1:0] w_addr;
    logic [5:0]        w_num;

    mpmc10_strip_addr_gen #(
        .ADDR_W     (ADDR_W),
        .STRIP_STEP (STRIP_STEP)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_load),
        .base_i     (adr),
        .last_idx_i (num_strips),
        .advance_i  (w_advance),
        .addr_o     (w_addr),
        .last_idx_o (w_num),
        .last_o     (w_last)
    );

    assign w_rd_beat = app_rd_data_valid &&
                       ((state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wnext_q     <= 1'b0;
            rd_cnt_q    <= '0;
            rdata_q     <= '0;
            rdata_idx_q <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wnext_q     <= wnext_d;
            rd_cnt_q    <= rd_cnt_d;
            rdata_q     <= rdata_d;
            rdata_idx_q <= rdata_idx_d;
            rdata_vld_q <= rdata_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        wnext_d     = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        rdata_d     = rdata_q;
        rdata_idx_d = rdata_idx_q;
        rdata_vld_d = 1'b0;

        if (w_rd_beat) begin
            rdata_d     = app_rd_data;
            rdata_idx_d = rd_cnt_q;
            rdata_vld_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 6'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    w_load   = 1'b1;
                    rd_cnt_d = '0;
                    state_d  = we ? ST_WR_DATA : ST_RD_CMD;
                end
            end
            ST_WR_DATA: begin
                if (app_wdf_rdy) begin
                    wnext_d = 1'b1;
                    state_d = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                if (app_rdy) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                        state_d   = ST_WR_DATA;
                    end
                end
            end
            ST_RD_CMD: begin
                if (app_rdy) begin
                    if (w_last) begin
                        state_d = ST_RD_WAIT;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (w_rd_beat && (rd_cnt_q == w_num)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so an async reset clears them at once.
    assign app_en       = (state_q == ST_WR_CMD) || (state_q == ST_RD_CMD);
    assign app_cmd      = (state_q == ST_RD_CMD) ? CMD_READ : CMD_WRITE;
    assign app_addr     = app_en ? w_addr : '0;
    assign app_wdf_wren = (state_q == ST_WR_DATA);
    assign app_wdf_end  = (state_q == ST_WR_DATA);
    assign app_wdf_data = app_wdf_wren ? wdata : '0;
    assign app_wdf_mask = app_wdf_wren ? wmask : '0;
    assign wnext        = wnext_q;
    assign rdata        = rdata_q;
    assign rdata_idx    = rdata_idx_q;
    assign rdata_vld    = rdata_vld_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mpmc10_strip_seq.sv
// ============================================================================
// Module : tb_mpmc10_strip_seq
// Brief  : Directed self-checking bench for the strip sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mpmc10_strip_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         req, we;
    logic [28:0]  adr;
    logic [5:0]   num_strips;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic         wnext;
    logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_rd_data;
    logic         app_en, app_wdf_wren, app_wdf_end;
    logic [2:0]   app_cmd;
    logic [28:0]  app_addr;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic [127:0] rdata;
    logic         rdata_vld;
    logic [5:0]   rdata_idx;
    logic         busy, done;

    int checks   = 0;
    int failures = 0;

    logic [28:0]  acc_addr[$];
    logic [2:0]   acc_cmd[$];
    logic [127:0] acc_wd[$];
    logic [15:0]  acc_wm[$];
    logic [5:0]   r_idx[$];
    logic [127:0] r_dat[$];
    int n_wnext, n_done, n_overlap, n_held, n_held_bad;
    int n_wr_stall, n_wr_bad, n_en_in_wr_stall, rvld_at_done;
    bit timed_out;

    always #5 clk = ~clk;

    mpmc10_strip_seq #(.ADDR_W(29), .STRIP_STEP(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr),
        .num_strips(num_strips), .wdata(wdata), .wmask(wmask), .wnext(wnext),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .rdata(rdata), .rdata_vld(rdata_vld),
        .rdata_idx(rdata_idx), .busy(busy), .done(done)
    );

    function automatic logic [127:0] wpat(input int i);
        return {4{32'hA5A5_0000 + 32'(i)}};
    endfunction

    function automatic logic [15:0] mpat(input int i);
        return 16'(i) ^ 16'h8001;
    endfunction

    function automatic logic [127:0] rpat(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // Drives one transfer with a cooperative MIG model and records what the DUT did.
    task automatic run_xfer(input logic we_v, input logic [28:0] a, input logic [5:0] n,
                            input int stall_at, input int stall_len, input int wdf_len,
                            input int req_pulse_at, input int max_cyc);
        int stall_left, wdf_left, post;
        logic prev_en_stall, prev_wr_stall;
        logic [28:0] prev_addr;
        logic [5:0] pend[$];
        acc_addr.delete(); acc_cmd.delete(); acc_wd.delete(); acc_wm.delete();
        r_idx.delete(); r_dat.delete();
        n_wnext = 0; n_done = 0; n_overlap = 0; n_held = 0; n_held_bad = 0;
        n_wr_stall = 0; n_wr_bad = 0; n_en_in_wr_stall = 0; rvld_at_done = -1;
        timed_out = 1'b1;
        stall_left = stall_len; wdf_left = wdf_len; post = -1;
        prev_en_stall = 1'b0; prev_wr_stall = 1'b0; prev_addr = '0;
        @(negedge clk);
        req = 1'b1; we = we_v; adr = a; num_strips = n;
        wdata = wpat(0); wmask = mpat(0);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            req = (c == req_pulse_at);
            if (req) begin
                we = ~we_v; adr = a ^ 29'h1000; num_strips = 6'd5;
            end
            if (prev_en_stall) begin
                n_held++;
                if (!app_en || app_addr !== prev_addr) n_held_bad++;
            end
            if (prev_wr_stall && !app_wdf_wren) n_wr_bad++;
            if (app_en && app_wdf_wren) n_overlap++;
            if (rdata_vld) begin
                r_idx.push_back(rdata_idx);
                r_dat.push_back(rdata);
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    rvld_at_done = r_idx.size();
                    post = 3;
                end
            end
            if (wnext) begin
                n_wnext++;
                wdata = wpat(n_wnext);
                wmask = mpat(n_wnext);
            end
            if (app_en && acc_addr.size() == stall_at && stall_left > 0) begin
                app_rdy = 1'b0;
                stall_left--;
            end else begin
                app_rdy = 1'b1;
            end
            prev_en_stall = app_en && !app_rdy;
            prev_addr = app_addr;
            if (app_en && app_rdy) begin
                acc_addr.push_back(app_addr);
                acc_cmd.push_back(app_cmd);
            end
            if (app_wdf_wren && wdf_left > 0) begin
                app_wdf_rdy = 1'b0;
                wdf_left--;
                n_wr_stall++;
                if (app_en) n_en_in_wr_stall++;
            end else begin
                app_wdf_rdy = 1'b1;
            end
            prev_wr_stall = app_wdf_wren && !app_wdf_rdy;
            if (app_wdf_wren && app_wdf_rdy) begin
                acc_wd.push_back(app_wdf_data);
                acc_wm.push_back(app_wdf_mask);
            end
            if (pend.size() > 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = rpat(int'(pend.pop_front()));
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = '0;
            end
            if (app_en && app_rdy && app_cmd == 3'b001) pend.push_back(6'(acc_addr.size() - 1));
            if (post == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (post > 0) post--;
        end
        req = 1'b0; app_rd_data_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        if (timed_out) begin
            checks++; failures++;
            $display("FAIL xfer_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; adr = '0; num_strips = '0;
        wdata = '0; wmask = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, app_en, app_wdf_wren, app_wdf_end, wnext, rdata_vld} !== 7'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0", {busy, done, app_en, app_wdf_wren, app_wdf_end, wnext, rdata_vld});
        end
        checks++; if (app_addr !== 29'h0 || app_cmd !== 3'b000) begin
            failures++; $display("FAIL reset_cmd_addr got=%0h/%0h exp=0/0", app_cmd, app_addr);
        end
        checks++; if (rdata !== 128'h0 || rdata_idx !== 6'h0 || app_wdf_data !== 128'h0) begin
            failures++; $display("FAIL reset_data got=%0h/%0h exp=0", rdata, rdata_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_basic();
        logic [28:0] exp_a;
        run_xfer(1'b1, 29'h100, 6'd2, -1, 0, 0, -1, 60);
        checks++; if (acc_addr.size() !== 3) begin
            failures++; $display("FAIL wr_cmd_count got=%0d exp=3", acc_addr.size());
        end
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
            exp_a = 29'h100 + 29'(8 * i);
            checks++; if (acc_addr[i] !== exp_a || acc_cmd[i] !== 3'b000) begin
                failures++; $display("FAIL wr_cmd%0d got=%0h/%0h exp=0/%0h", i, acc_cmd[i], acc_addr[i], exp_a);
            end
        end
        for (int i = 0; i < 3 && i < acc_wd.size(); i++) begin
            checks++; if (acc_wd[i] !== wpat(i) || acc_wm[i] !== mpat(i)) begin
                failures++; $display("FAIL wr_beat%0d got=%0h/%0h exp=%0h/%0h", i, acc_wd[i], acc_wm[i], wpat(i), mpat(i));
            end
        end
        checks++; if (n_wnext !== 3 || acc_wd.size() !== 3) begin
            failures++; $display("FAIL wr_wnext got=%0d beats=%0d exp=3", n_wnext, acc_wd.size());
        end
        checks++; if (n_done !== 1 || n_overlap !== 0) begin
            failures++; $display("FAIL wr_done_overlap got=%0d/%0d exp=1/0", n_done, n_overlap);
        end
    endtask

    task automatic test_read_stall();
        logic [28:0] exp_a;
        run_xfer(1'b0, 29'h400, 6'd3, 1, 2, 0, -1, 60);
        checks++; if (acc_addr.size() !== 4) begin
            failures++; $display("FAIL rd_cmd_count got=%0d exp=4", acc_addr.size());
        end
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            exp_a = 29'h400 + 29'(8 * i);
            checks++; if (acc_addr[i] !== exp_a || acc_cmd[i] !== 3'b001) begin
                failures++; $display("FAIL rd_cmd%0d got=%0h/%0h exp=1/%0h", i, acc_cmd[i], acc_addr[i], exp_a);
            end
        end
        checks++; if (n_held !== 2 || n_held_bad !== 0) begin
            failures++; $display("FAIL rd_stall_hold got=%0d bad=%0d exp=2 bad=0", n_held, n_held_bad);
        end
        checks++; if (r_idx.size() !== 4) begin
            failures++; $display("FAIL rd_beat_count got=%0d exp=4", r_idx.size());
        end
        for (int i = 0; i < 4 && i < r_idx.size(); i++) begin
            checks++; if (r_idx[i] !== 6'(i) || r_dat[i] !== rpat(i)) begin
                failures++; $display("FAIL rd_beat%0d got=%0d/%0h exp=%0d/%0h", i, r_idx[i], r_dat[i], i, rpat(i));
            end
        end
        checks++; if (n_done !== 1 || rvld_at_done !== 4) begin
            failures++; $display("FAIL rd_done got=%0d beats_at_done=%0d exp=1/4", n_done, rvld_at_done);
        end
    endtask

    task automatic test_wdf_stall();
        run_xfer(1'b1, 29'h800, 6'd0, -1, 0, 3, -1, 40);
        checks++; if (n_wr_stall !== 3 || n_wr_bad !== 0) begin
            failures++; $display("FAIL wdf_stall_hold got=%0d bad=%0d exp=3/0", n_wr_stall, n_wr_bad);
        end
        checks++; if (n_en_in_wr_stall !== 0 || n_overlap !== 0) begin
            failures++; $display("FAIL wdf_stall_en got=%0d/%0d exp=0/0", n_en_in_wr_stall, n_overlap);
        end
        checks++; if (n_wnext !== 1 || acc_addr.size() !== 1 || n_done !== 1) begin
            failures++; $display("FAIL wdf_stall_counts got=%0d/%0d/%0d exp=1/1/1", n_wnext, acc_addr.size(), n_done);
        end
        checks++; if (acc_wd.size() < 1 || acc_wd[0] !== wpat(0)) begin
            failures++; $display("FAIL wdf_stall_data beats=%0d exp=1 data %0h", acc_wd.size(), wpat(0));
        end
    endtask

    task automatic test_wrap();
        run_xfer(1'b1, 29'h1FFF_FFF8, 6'd1, -1, 0, 0, -1, 40);
        checks++; if (acc_addr.size() !== 2) begin
            failures++; $display("FAIL wrap_count got=%0d exp=2", acc_addr.size());
        end else begin
            checks++; if (acc_addr[0] !== 29'h1FFF_FFF8 || acc_addr[1] !== 29'h0) begin
                failures++; $display("FAIL wrap_addr got=%0h,%0h exp=1ffffff8,0", acc_addr[0], acc_addr[1]);
            end
        end
    endtask

    task automatic test_max_strips();
        run_xfer(1'b1, 29'h2000, 6'd63, -1, 0, 0, -1, 400);
        checks++; if (acc_addr.size() !== 64 || n_wnext !== 64 || n_done !== 1) begin
            failures++; $display("FAIL max_counts got=%0d/%0d/%0d exp=64/64/1", acc_addr.size(), n_wnext, n_done);
        end
        if (acc_addr.size() == 64) begin
            checks++; if (acc_addr[63] !== 29'h21F8) begin
                failures++; $display("FAIL max_last_addr got=%0h exp=21f8", acc_addr[63]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 29'h200; num_strips = 6'd3; app_rdy = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checks++; if (app_en !== 1'b1 || app_addr !== 29'h208) begin
            failures++; $display("FAIL rstmid_pre got=%b/%0h exp=1/208", app_en, app_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({app_en, busy, done, app_wdf_wren, rdata_vld} !== 5'b0 || app_addr !== 29'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%b/%0h exp=0/0", {app_en, busy, done, app_wdf_wren, rdata_vld}, app_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (app_en || app_wdf_wren || busy) stray++;
        end
        checks++; if (stray !== 0) begin
            failures++; $display("FAIL rstmid_quiet got=%0d exp=0", stray);
        end
        run_xfer(1'b0, 29'h300, 6'd0, -1, 0, 0, -1, 40);
        checks++; if (acc_addr.size() !== 1 || n_done !== 1 || r_idx.size() !== 1) begin
            failures++; $display("FAIL rstmid_single got=%0d/%0d/%0d exp=1/1/1", acc_addr.size(), n_done, r_idx.size());
        end else begin
            checks++; if (acc_addr[0] !== 29'h300 || r_idx[0] !== 6'd0 || r_dat[0] !== rpat(0)) begin
                failures++; $display("FAIL rstmid_addr got=%0h/%0d exp=300/0", acc_addr[0], r_idx[0]);
            end
        end
    endtask

    task automatic test_ignore();
        int stray;
        stray = 0;
        @(negedge clk);
        app_rd_data_valid = 1'b1; app_rd_data = 128'hDEAD;
        repeat (3) begin
            @(negedge clk);
            if (rdata_vld || busy) stray++;
        end
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        if (rdata_vld) stray++;
        checks++; if (stray !== 0) begin
            failures++; $display("FAIL idle_valid got=%0d exp=0", stray);
        end
        run_xfer(1'b1, 29'h40, 6'd0, -1, 0, 0, 1, 40);
        checks++; if (acc_addr.size() !== 1 || n_done !== 1 || r_idx.size() !== 0) begin
            failures++; $display("FAIL busy_req got=%0d/%0d/%0d exp=1/1/0", acc_addr.size(), n_done, r_idx.size());
        end else begin
            checks++; if (acc_addr[0] !== 29'h40 || acc_cmd[0] !== 3'b000) begin
                failures++; $display("FAIL busy_req_cmd got=%0h/%0h exp=0/40", acc_cmd[0], acc_addr[0]);
            end
        end
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL busy_req_idle got=%b exp=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_wdf_stall();
        test_wrap();
        test_max_strips();
        test_reset_mid();
        test_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
